// File: rtl/usb_in_ep_sequencer_if.sv
// Packet-level link between the IN endpoint sequencer and the USB packet receiver/transmitter.
// master = sequencer side, slave = packet decoder/encoder side.
interface usb_in_ep_sequencer_if;
    logic       rx_valid;
    logic [3:0] rx_pid;
    logic [6:0] rx_addr;
    logic [3:0] rx_endp;
    logic       rx_crc_ok;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_payload;
    logic       tx_done;

    modport master (
        input  rx_valid, rx_pid, rx_addr, rx_endp, rx_crc_ok, tx_done,
        output tx_start, tx_pid, tx_payload
    );

    modport slave (
        output rx_valid, rx_pid, rx_addr, rx_endp, rx_crc_ok, tx_done,
        input  tx_start, tx_pid, tx_payload
    );
endinterface

// File: rtl/usb_in_ep_sequencer.sv
// Interrupt IN endpoint sequencer: answers IN tokens with DATA0/1, NAK or STALL,
// tracks the data toggle and signals record delivery to the time-record buffer.
//
// state      | meaning
// IDLE       | waiting for a matching IN token
// SEND_DATA  | transmitter sending DATA0/DATA1 with the time record
// SEND_NAK   | transmitter sending NAK (no record ready)
// SEND_STALL | transmitter sending STALL (endpoint halted)
// WAIT_HS    | DATA sent, waiting for the host handshake
module usb_in_ep_sequencer #(
    parameter logic [3:0] EP_NUM     = 4'd1,
    parameter int         HS_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [6:0]                    dev_addr,
    input  logic                          ep_halt,
    input  logic                          toggle_clear,
    input  logic                          bus_reset,
    input  logic                          data_avail,
    output logic                          data_consume,
    output logic                          toggle,
    output logic                          busy,
    output logic                          hs_timeout,
    usb_in_ep_sequencer_if.master         usb
);

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam int              CNT_W    = $clog2(HS_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_DATA,
        SEND_NAK,
        SEND_STALL,
        WAIT_HS
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggle_q, toggle_d;
    logic             tx_start_q, tx_start_d;
    logic [3:0]       tx_pid_q, tx_pid_d;
    logic             tx_payload_q, tx_payload_d;
    logic             consume_d;
    logic             timeout_d;
    logic             token_match;

    assign token_match = usb.rx_valid && (usb.rx_pid == PID_IN) && usb.rx_crc_ok
                         && (usb.rx_addr == dev_addr) && (usb.rx_endp == EP_NUM);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        toggle_d     = toggle_q;
        tx_start_d   = 1'b0;
        tx_pid_d     = tx_pid_q;
        tx_payload_d = tx_payload_q;
        consume_d    = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (token_match) begin
                    tx_start_d = 1'b1;
                    if (ep_halt) begin
                        state_d      = SEND_STALL;
                        tx_pid_d     = PID_STALL;
                        tx_payload_d = 1'b0;
                    end else if (data_avail) begin
                        state_d      = SEND_DATA;
                        tx_pid_d     = toggle_q ? PID_DATA1 : PID_DATA0;
                        tx_payload_d = 1'b1;
                    end else begin
                        state_d      = SEND_NAK;
                        tx_pid_d     = PID_NAK;
                        tx_payload_d = 1'b0;
                    end
                end
            end
            SEND_DATA: begin
                if (usb.tx_done) begin
                    state_d      = WAIT_HS;
                    cnt_d        = '0;
                    tx_payload_d = 1'b0;
                end
            end
            SEND_NAK, SEND_STALL: begin
                if (usb.tx_done) state_d = IDLE;
            end
            WAIT_HS: begin
                cnt_d = cnt_q + 1'b1;
                // Any handshake ends the wait; only ACK advances the toggle and frees the record.
                if (usb.rx_valid) begin
                    state_d = IDLE;
                    if (usb.rx_pid == PID_ACK) begin
                        toggle_d  = ~toggle_q;
                        consume_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (toggle_clear) toggle_d = 1'b0;

        if (bus_reset || reset) begin
            state_d      = IDLE;
            cnt_d        = '0;
            toggle_d     = 1'b0;
            tx_start_d   = 1'b0;
            tx_pid_d     = PID_NAK;
            tx_payload_d = 1'b0;
            consume_d    = 1'b0;
            timeout_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            toggle_q     <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_pid_q     <= PID_NAK;
            tx_payload_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            toggle_q     <= toggle_d;
            tx_start_q   <= tx_start_d;
            tx_pid_q     <= tx_pid_d;
            tx_payload_q <= tx_payload_d;
        end
    end

    assign usb.tx_start   = tx_start_q;
    assign usb.tx_pid     = tx_pid_q;
    assign usb.tx_payload = tx_payload_q;
    assign toggle         = toggle_q;
    assign busy           = (state_q != IDLE);
    assign data_consume   = consume_d;
    assign hs_timeout     = timeout_d;

endmodule

// File: doc/usb_in_ep_sequencer.md
Name: usb_in_ep_sequencer

Overview:
Transaction sequencer for the low-speed USB interrupt IN endpoint that delivers decoded DCF77 time records (BCD) to the host. It takes decoded token/handshake PIDs from the packet receiver and decides the response: DATA0/DATA1, NAK or STALL. It issues that response to the packet transmitter, waits for the host handshake, and maintains the data toggle. It also tells the time-record buffer when a record has been delivered. It sits between the USB packet decoder/encoder and the DCF77 time-record buffer.

Parameters:
EP_NUM, 4'd1, endpoint number this sequencer answers
HS_TIMEOUT, 16, clk cycles to wait for host handshake after DATA packet ends (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dev_addr  in  7  assigned device address (from control endpoint)
ep_halt  in  1  endpoint halted; answer IN with STALL
toggle_clear  in  1  1-cycle pulse: force data toggle to DATA0
bus_reset  in  1  USB bus reset detected (SE0 state); level
rx_valid  in  1  1-cycle pulse: PID/token fields valid
rx_pid  in  4  received PID, pid_t encoding
rx_addr  in  7  token address field
rx_endp  in  4  token endpoint field
rx_crc_ok  in  1  token CRC5 correct (qualifies rx_valid for tokens)
data_avail  in  1  time record ready for transmission
data_consume  out  1  1-cycle pulse: record delivered and ACKed
tx_start  out  1  1-cycle pulse: start transmitting tx_pid
tx_pid  out  4  PID to transmit, pid_t encoding; stable from tx_start to tx_done
tx_payload  out  1  attach record payload + CRC16 (DATA PIDs only)
tx_done  in  1  1-cycle pulse: transmitter finished (EOP sent)
toggle  out  1  current data toggle (0=DATA0, 1=DATA1)
busy  out  1  high in any state except IDLE
hs_timeout  out  1  1-cycle pulse: handshake wait expired

Behaviour:
- Reset values: state IDLE; toggle=0; tx_start=0; tx_pid=NAK; tx_payload=0; data_consume=0; hs_timeout=0; busy=0; timeout counter 0.
- States: IDLE, SEND_DATA, SEND_NAK, SEND_STALL, WAIT_HS.
- IDLE: a token matches when rx_valid & rx_pid==IN & rx_crc_ok & rx_addr==dev_addr & rx_endp==EP_NUM.
  - Matching IN token, priority order: ep_halt -> SEND_STALL; else data_avail -> SEND_DATA; else -> SEND_NAK.
  - The branch decision samples ep_halt and data_avail in the cycle rx_valid is high.
  - All other rx_valid events in IDLE are ignored: non-IN PIDs, CRC errors, address or endpoint mismatch.
- Entry into each SEND_* state:
  - tx_start pulses in the first cycle of the state, registered one cycle after the matching rx_valid.
  - tx_pid = DATA0/DATA1 per toggle, or NAK, or STALL.
  - tx_payload=1 only in SEND_DATA.
  - tx_pid and tx_payload are held until tx_done.
- On tx_done: SEND_DATA -> WAIT_HS with counter cleared; SEND_NAK/SEND_STALL -> IDLE.
- WAIT_HS: counter increments every cycle.
  - rx_valid & rx_pid==ACK: toggle inverts; data_consume pulses in the same cycle as the transition to IDLE.
  - rx_valid with any other PID: -> IDLE; toggle unchanged; no consume. The host will retry the same record.
  - Counter reaches HS_TIMEOUT-1 with no rx_valid: hs_timeout pulses; -> IDLE; toggle unchanged; no consume.
  - ACK arriving in the same cycle the counter expires: ACK wins.
- rx_valid while in any SEND_* state is ignored (half-duplex bus).
- toggle_clear: toggle=0 next cycle, in any state.
  - If it coincides with an ACK in WAIT_HS, clear wins (toggle=0), but data_consume still pulses.
- bus_reset (level), in any state: state -> IDLE, toggle=0, tx_start suppressed, no data_consume. Persists while high.
  - A transfer in progress is abandoned and tx_pid returns to NAK.
- reset mid-transaction behaves identically to bus_reset, plus all outputs return to reset values.
- busy = (state != IDLE).
- Maximum latency from matching IN token to tx_start: 1 cycle.

Test Plan:
- dev_addr=5, data_avail=1, IN to addr 5 ep 1 with CRC ok -> tx_start 1 cycle later, tx_pid=DATA0 (0011), tx_payload=1. tx_done then ACK -> data_consume pulse, toggle=1. Second IN -> tx_pid=DATA1 (1011).
- data_avail=0, matching IN -> tx_pid=NAK (1010), tx_payload=0, back to IDLE on tx_done. ep_halt=1 with data_avail=1 -> tx_pid=STALL (1110).
- IN with rx_crc_ok=0, IN to addr 6, IN to ep 2, and OUT to addr 5 ep 1 -> no tx_start, busy stays 0.
- DATA0 sent, no handshake for HS_TIMEOUT=16 cycles -> hs_timeout pulse at cycle 16 after tx_done, toggle stays 0, no consume. Retry IN -> DATA0 again.
- Handshake arrives as NAK instead of ACK -> IDLE, toggle unchanged, no consume. ACK and toggle_clear in same cycle -> toggle=0, data_consume=1.
- bus_reset asserted in SEND_DATA (before tx_done) with toggle=1 -> IDLE next cycle, toggle=0, tx_pid=NAK, no data_consume. reset in WAIT_HS -> all outputs return to reset values.
